// File: rtl/lsu_mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mmio_bridge
// Purpose  : LSU-to-MMIO bridge; decodes CLINT vs. memory, RMW for CLINT
//            sub-dword stores, byte-masked memory port, extended load data.
// Option   : define LSU_MISALIGN_TRAP_EN to trap misaligned accesses
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mmio_bridge #(
   parameter int                 ADR_W      = 32,
   parameter int                 CPU_W      = 64,
   parameter logic [ADR_W-1:0]   CLINT_BASE = 32'h0200_0000,
   parameter logic [ADR_W-1:0]   CLINT_MASK = 32'hFFFF_0000
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_req_valid,
   output logic                 o_req_ready,
   input  logic                 i_req_wen,
   input  logic [ADR_W-1:0]     i_req_addr,
   input  logic [CPU_W-1:0]     i_req_wdata,
   input  logic [1:0]           i_req_size,
   input  logic                 i_req_unsigned,
   output logic                 o_rsp_valid,
   input  logic                 i_rsp_ready,
   output logic [CPU_W-1:0]     o_rsp_rdata,
   output logic                 o_rsp_err,
   output logic                 o_clint_ren,
   output logic [ADR_W-1:0]     o_clint_raddr,
   input  logic [CPU_W-1:0]     i_clint_rdata,
   output logic                 o_clint_wen,
   output logic [ADR_W-1:0]     o_clint_waddr,
   output logic [CPU_W-1:0]     o_clint_wdata,
   output logic                 o_mem_valid,
   input  logic                 i_mem_ready,
   output logic                 o_mem_wen,
   output logic [ADR_W-1:0]     o_mem_addr,
   output logic [CPU_W-1:0]     o_mem_wdata,
   output logic [7:0]           o_mem_wmask,
   input  logic                 i_mem_rvalid,
   input  logic [CPU_W-1:0]     i_mem_rdata
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CLINT    = 3'd1,
      S_CLINT_WR = 3'd2,
      S_MEM_REQ  = 3'd3,
      S_MEM_RSP  = 3'd4,
`ifdef LSU_MISALIGN_TRAP_EN
      S_ERR      = 3'd5,
`endif
      S_RSP      = 3'd6
   } state_t;

   state_t              r_state;
   state_t              w_next_state;

   logic [ADR_W-1:0]    r_addr;
   logic [CPU_W-1:0]    r_wdata;
   logic [1:0]          r_size;
   logic                r_wen;
   logic                r_unsigned;
   logic [CPU_W-1:0]    r_rsp_rdata;
   logic [CPU_W-1:0]    r_old;

   logic                w_accept;
   logic [2:0]          w_size_mask;
   logic [ADR_W-1:0]    w_req_addr;
   logic                w_is_clint;
   logic [5:0]          w_shamt;
   logic [7:0]          w_lane_mask;
   logic [CPU_W-1:0]    w_bit_mask;
   logic [CPU_W-1:0]    w_wdata_sh;
   logic [CPU_W-1:0]    w_merge;
   logic [ADR_W-1:0]    w_dword_addr;
   logic                w_is_dword;
   logic [CPU_W-1:0]    w_ld_src;
   logic [CPU_W-1:0]    w_ld_data;

   // Right-justify the addressed lanes, then sign/zero extend by size.
   function automatic logic [CPU_W-1:0] f_extract(
      input logic [CPU_W-1:0] dword,
      input logic [5:0]       shamt,
      input logic [1:0]       size,
      input logic             uns
   );
      logic [CPU_W-1:0] sh;
      sh = dword >> shamt;
      case (size)
         2'd0:    f_extract = uns ? {{(CPU_W-8){1'b0}},  sh[7:0]}
                                  : {{(CPU_W-8){sh[7]}},  sh[7:0]};
         2'd1:    f_extract = uns ? {{(CPU_W-16){1'b0}}, sh[15:0]}
                                  : {{(CPU_W-16){sh[15]}}, sh[15:0]};
         2'd2:    f_extract = uns ? {{(CPU_W-32){1'b0}}, sh[31:0]}
                                  : {{(CPU_W-32){sh[31]}}, sh[31:0]};
         default: f_extract = sh;
      endcase
   endfunction

   assign w_accept    = i_req_valid && (r_state == S_IDLE);
   assign o_req_ready = (r_state == S_IDLE);
   assign o_rsp_valid = (r_state == S_RSP);
   assign o_rsp_rdata = o_rsp_valid ? r_rsp_rdata : '0;

   always_comb begin
      case (i_req_size)
         2'd0:    w_size_mask = 3'b000;
         2'd1:    w_size_mask = 3'b001;
         2'd2:    w_size_mask = 3'b011;
         default: w_size_mask = 3'b111;
      endcase
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic w_misaligned;
   logic r_err;

   assign w_misaligned = |(i_req_addr[2:0] & w_size_mask);
   assign w_req_addr   = i_req_addr;
   assign o_rsp_err    = o_rsp_valid && r_err;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)      r_err <= 1'b0;
      else if (w_accept) r_err <= w_misaligned;
   end
`else
   // Without trapping, the offset is silently aligned down to the access size.
   assign w_req_addr = {i_req_addr[ADR_W-1:3], i_req_addr[2:0] & ~w_size_mask};
   assign o_rsp_err  = 1'b0;
`endif

   assign w_is_clint   = ((w_req_addr & CLINT_MASK) == CLINT_BASE);

   assign w_shamt      = {r_addr[2:0], 3'b000};
   assign w_dword_addr = {r_addr[ADR_W-1:3], 3'b000};
   assign w_is_dword   = (r_size == 2'd3);
   assign w_wdata_sh   = r_wdata << w_shamt;

   always_comb begin
      case (r_size)
         2'd0:    w_lane_mask = 8'h01 << r_addr[2:0];
         2'd1:    w_lane_mask = 8'h03 << r_addr[2:0];
         2'd2:    w_lane_mask = 8'h0F << r_addr[2:0];
         default: w_lane_mask = 8'hFF;
      endcase
   end

   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign w_bit_mask[8*gi +: 8] = {8{w_lane_mask[gi]}};
   end

   assign w_merge   = (r_old & ~w_bit_mask) | (w_wdata_sh & w_bit_mask);
   assign w_ld_src  = (r_state == S_CLINT) ? i_clint_rdata : i_mem_rdata;
   assign w_ld_data = f_extract(w_ld_src, w_shamt, r_size, r_unsigned);

   always_comb begin
      w_next_state  = r_state;
      o_clint_ren   = 1'b0;
      o_clint_raddr = '0;
      o_clint_wen   = 1'b0;
      o_clint_waddr = '0;
      o_clint_wdata = '0;
      o_mem_valid   = 1'b0;
      o_mem_wen     = 1'b0;
      o_mem_addr    = '0;
      o_mem_wdata   = '0;
      o_mem_wmask   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
`ifdef LSU_MISALIGN_TRAP_EN
               if (w_misaligned)    w_next_state = S_ERR;
               else if (w_is_clint) w_next_state = S_CLINT;
               else                 w_next_state = S_MEM_REQ;
`else
               if (w_is_clint)      w_next_state = S_CLINT;
               else                 w_next_state = S_MEM_REQ;
`endif
            end
         end
         S_CLINT: begin
            o_clint_ren   = 1'b1;
            o_clint_raddr = w_dword_addr;
            // A full dword store needs no merge and writes alongside the read.
            if (r_wen && w_is_dword) begin
               o_clint_wen   = 1'b1;
               o_clint_waddr = w_dword_addr;
               o_clint_wdata = r_wdata;
            end
            w_next_state = (r_wen && !w_is_dword) ? S_CLINT_WR : S_RSP;
         end
         S_CLINT_WR: begin
            o_clint_wen   = 1'b1;
            o_clint_waddr = w_dword_addr;
            o_clint_wdata = w_merge;
            w_next_state  = S_RSP;
         end
         S_MEM_REQ: begin
            o_mem_valid = 1'b1;
            o_mem_wen   = r_wen;
            o_mem_addr  = w_dword_addr;
            o_mem_wdata = w_wdata_sh;
            o_mem_wmask = w_lane_mask;
            if (i_mem_ready) w_next_state = r_wen ? S_RSP : S_MEM_RSP;
         end
         S_MEM_RSP: begin
            if (i_mem_rvalid) w_next_state = S_RSP;
         end
`ifdef LSU_MISALIGN_TRAP_EN
         S_ERR: begin
            w_next_state = S_RSP;
         end
`endif
         S_RSP: begin
            if (i_rsp_ready) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_size      <= '0;
         r_wen       <= 1'b0;
         r_unsigned  <= 1'b0;
         r_rsp_rdata <= '0;
         r_old       <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_addr      <= w_req_addr;
            r_wdata     <= i_req_wdata;
            r_size      <= i_req_size;
            r_wen       <= i_req_wen;
            r_unsigned  <= i_req_unsigned;
            r_rsp_rdata <= '0;
         end
         if (r_state == S_CLINT) begin
            r_old <= i_clint_rdata;
            if (!r_wen) r_rsp_rdata <= w_ld_data;
         end
         if ((r_state == S_MEM_RSP) && i_mem_rvalid) r_rsp_rdata <= w_ld_data;
      end
   end

endmodule
`default_nettype wire
